// File: rtl/mx_ifetch_queue_pkg.sv
// Shared MX fetch-path types and width defaults.
package mx_pkg;
    localparam int MX_ADDR_W = 8;
    localparam int MX_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/mx_ifetch_queue_if.sv
// BIU fetch bus plus the decoder-side valid/ready instruction stream.
interface mx_ifetch_queue_if
    import mx_pkg::*;
#(
    parameter int ADDR_WIDTH = MX_ADDR_W,
    parameter int DATA_WIDTH = MX_DATA_W
);
    logic [ADDR_WIDTH-1:0] insp;
    logic                  ce_n;
    logic [DATA_WIDTH-1:0] insr;
    logic                  valid;
    logic                  ins_valid;
    logic                  ins_ready;
    logic [DATA_WIDTH-1:0] ins_data;
    logic [ADDR_WIDTH-1:0] ins_pc;

    modport master (
        output insp, ce_n, ins_valid, ins_data, ins_pc,
        input  insr, valid, ins_ready
    );

    modport slave (
        input  insp, ce_n, ins_valid, ins_data, ins_pc,
        output insr, valid, ins_ready
    );
endinterface

// File: rtl/mx_sync_fifo.sv
// Small synchronous FIFO with clear and occupancy count.
module mx_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wptr] <= wdata;
    end
endmodule

// File: rtl/mx_ifetch_queue.sv
// Instruction prefetch stage: owns the fetch PC, drives the BIU and
// queues returned words with their addresses for the decoder.
module mx_ifetch_queue
    import mx_pkg::*;
#(
    parameter int                    ADDR_WIDTH = MX_ADDR_W,
    parameter int                    DATA_WIDTH = MX_DATA_W,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    mx_ifetch_queue_if.master      bus,
    input  logic                   fetch_en,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic [$clog2(DEPTH):0] count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    fetch_state_e          state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] insp_q;
    logic                  ce_n_q;
    logic                  discard;
    logic                  start;
    logic                  push;
    logic                  pop;
    logic [EW-1:0]         head;

    assign start = (state == IDLE) && fetch_en && !redirect && (count < FULL);
    assign push  = (state == CAPTURE) && !discard && !redirect;
    assign pop   = bus.ins_valid && bus.ins_ready;

    assign bus.insp      = insp_q;
    assign bus.ce_n      = ce_n_q;
    assign bus.ins_valid = (count != '0);
    assign bus.ins_pc    = head[EW-1:DATA_WIDTH];
    assign bus.ins_data  = head[DATA_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            insp_q  <= RESET_PC;
            ce_n_q  <= 1'b1;
            discard <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        insp_q <= pc;
                        ce_n_q <= 1'b0;
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    // The bus read always runs to completion; a flush only marks it stale.
                    if (redirect) discard <= 1'b1;
                    if (bus.valid) begin
                        ce_n_q <= 1'b1;
                        state  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (push) pc <= insp_q + ADDR_WIDTH'(1);
                    discard <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (redirect) pc <= redirect_pc;
        end
    end

    mx_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (redirect),
        .push  (push),
        .wdata ({insp_q, bus.insr}),
        .pop   (pop),
        .rdata (head),
        .count (count)
    );
endmodule

// File: doc/mx_ifetch_queue.md
Name: mx_ifetch_queue

Overview:
- Instruction prefetch stage sitting directly upstream of the instruction bus-interface unit (mxbiu_ins).
- Owns the fetch program counter and drives insp/ce_n into the BIU.
- Captures each returned instruction word into a small FIFO together with its address, and presents it to the decoder through a valid/ready handshake.
- Supports a redirect (branch) flush; a bus read already in flight is always allowed to finish, and its data is then dropped.

Parameters:
- ADDR_WIDTH, 8: instruction address width; must match the BIU.
- DATA_WIDTH, 8: instruction word width; must match the BIU.
- DEPTH, 4: number of FIFO entries; must be a power of two and at least 2.
- RESET_PC, 0: fetch address loaded at reset.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- insp  out  ADDR_WIDTH  fetch address to the BIU; held stable while a fetch is outstanding.
- ce_n  out  1  fetch request to the BIU, active-low.
- insr  in  DATA_WIDTH  instruction word from the BIU.
- valid  in  1  BIU completion pulse.
- fetch_en  in  1  when high, new fetches may start.
- redirect  in  1  branch flush pulse.
- redirect_pc  in  ADDR_WIDTH  new fetch address, sampled when redirect is high.
- ins_valid  out  1  FIFO head entry is valid.
- ins_ready  in  1  decoder accepts the head entry.
- ins_data  out  DATA_WIDTH  head instruction word.
- ins_pc  out  ADDR_WIDTH  address of the head instruction.
- count  out  $clog2(DEPTH)+1  number of FIFO entries in use.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, ce_n=1, insp=RESET_PC, pc=RESET_PC, discard=0.
  - FIFO emptied: count=0, ins_valid=0.
  - ins_data and ins_pc are don't-care while ins_valid=0.
- BIU contract:
  - The BIU starts a read when ce_n is low in its idle state.
  - It pulses valid for one cycle on completion.
  - insr is registered by the BIU on that same edge, so it is stable from the cycle after valid onward.
  - insp is used combinationally for the whole transaction.
- Fetch FSM (ce_n and insp are registered):
  - IDLE: if fetch_en=1, count<DEPTH and redirect=0, then insp<=pc, ce_n<=0, go to FETCH.
  - FETCH: ce_n stays 0 and insp is held. On valid=1, ce_n<=1 and go to CAPTURE; ce_n is therefore high before the BIU's next idle sample, so the fetch is not repeated.
  - CAPTURE (one cycle):
    - If discard=0 and redirect=0: push {insp, insr} into the FIFO and set pc<=insp+1.
    - Otherwise drop the data.
    - Clear discard and go to IDLE.
- Throughput: at most one fetch outstanding. With a zero-wait BIU, one word is fetched every 4 cycles or more.
- PC arithmetic: modulo 2^ADDR_WIDTH; all-ones wraps to 0.
- Redirect (highest priority; always sampled):
  - pc<=redirect_pc.
  - FIFO cleared that cycle (count=0); a simultaneous dequeue is ignored.
  - In FETCH: discard<=1, insp is held, and the bus transaction completes normally.
  - In CAPTURE: the word is dropped.
  - In IDLE: no fetch starts in the redirect cycle; the next fetch uses redirect_pc.
  - Redirect in the same cycle as valid: discard is set and the word is dropped.
- FIFO:
  - ins_valid = (count!=0). A dequeue occurs when ins_valid & ins_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Full cannot overflow: a fetch starts only when count<DEPTH, and nothing else pushes.
  - Pop on empty is a no-op.
  - Read and write pointers wrap modulo DEPTH.
- fetch_en low: no new fetch starts; an in-flight fetch still completes and is pushed (unless discarded).
- No combinational path from ins_ready to ce_n or insp.

Decomposition:
- Shared package mx_pkg holds:
  - fetch-state enum: IDLE, FETCH, CAPTURE (2-bit encoding).
  - shared MX address/data width defaults.
- One sub-module: mx_sync_fifo (parameterised width and depth, synchronous clear, count output). It stores {pc, word} entries.
- The FSM, pc logic and redirect logic stay in the top module.

Test Plan:
- Reset release, fetch_en=1, BIU completing 2 cycles after ce_n falls -> insp 0,1,2,3 in order; ins_data/ins_pc pairs (0,W0)…(3,W3); count reaches 4; no fifth fetch while ins_ready=0.
- Full FIFO, then ins_ready=1 for one cycle -> count 4→3, next fetch at insp=4 starts in the following IDLE cycle, count returns to 4.
- Redirect to 0x40 while FETCH of 0x05 is outstanding -> insp stays 0x05 until valid; word dropped; next fetch insp=0x40; first ins_pc out=0x40.
- Redirect in the same cycle as a dequeue with count=3 -> count=0 next cycle, ins_valid=0.
- pc=0xFF (ADDR_WIDTH=8) -> fetch 0xFF, then fetch 0x00.
- Reset asserted mid-FETCH -> ce_n=1 and count=0 immediately; after release, the first insp is RESET_PC.
